glb_fifo_arbiter: RTL and testbench

Shares the single GLB SRAM port among the 96 FIFO-side requesters of the token engine: 32 ifmap read lanes, 32 ipsum read lanes and 32 opsum write lanes. It grants one transaction at a time, drives the GLB address, write-enable and write-data lines, and returns one-hot permits to the winning lane controller. It also drives the shared `fifo_glb_busy` flag consumed by every lane controller. It sits between the L3 FIFO control array and the GLB.

---
 rtl/glb_fifo_arbiter.sv | 172 +++++++++++++++++
 tb/tb_glb_fifo_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/glb_fifo_arbiter.sv
// Single-port GLB arbiter for the 96 FIFO-side lanes (opsum write, ipsum/ifmap read).
// Build option: define GLB_ARB_CLASS_RR_EN for round-robin class selection (default: opsum > ipsum > ifmap).
module glb_fifo_arbiter #(
  parameter int NUM_LANE = 32,
  parameter int ADDR_W   = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_LANE-1:0]                ifmap_read_req_matrix_i,
  input  logic [NUM_LANE-1:0][ADDR_W-1:0]    ifmap_glb_read_addr_matrix_i,
  input  logic [NUM_LANE-1:0]                ipsum_read_req_matrix_i,
  input  logic [NUM_LANE-1:0][ADDR_W-1:0]    ipsum_glb_read_addr_matrix_i,
  input  logic [NUM_LANE-1:0]                opsum_glb_write_req_matrix_i,
  input  logic [NUM_LANE-1:0][ADDR_W-1:0]    opsum_glb_write_addr_matrix_i,
  input  logic [NUM_LANE-1:0][3:0]           opsum_glb_write_web_matrix_i,
  input  logic [NUM_LANE-1:0][31:0]          opsum_fifo_pop_data_matrix_i,
  output logic [NUM_LANE-1:0]                ifmap_permit_push_matrix_o,
  output logic [NUM_LANE-1:0]                ipsum_permit_push_matrix_o,
  output logic [NUM_LANE-1:0]                opsum_permit_pop_matrix_o,
  output logic [ADDR_W-1:0]                  glb_addr_o,
  output logic [3:0]                         glb_web_o,
  output logic [31:0]                        glb_wdata_o,
  output logic                               glb_en_o,
  output logic                               fifo_glb_busy_o
);
  localparam int LW = $clog2(NUM_LANE);
  localparam logic [1:0] CLS_OPS = 2'd0, CLS_IPS = 2'd1, CLS_IFM = 2'd2;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cls_q, cls_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [2:0][LW-1:0]      ptr_q, ptr_d;
  logic [NUM_LANE-1:0]     ifm_push_q, ifm_push_d, ips_push_q, ips_push_d, ops_pop_q, ops_pop_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [3:0]              web_q, web_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    en_q, en_d, busy_q, busy_d;
`ifdef GLB_ARB_CLASS_RR_EN
  logic [1:0]              cptr_q, cptr_d;
`endif

  // Returns {found, lane}: first requester at or after ptr, wrapping.
  function automatic logic [LW:0] rr_pick(input logic [NUM_LANE-1:0] req, input logic [LW-1:0] ptr);
    logic [LW:0] r;
    int          j;
    r = '0;
    for (int i = NUM_LANE-1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_LANE) j = j - NUM_LANE;
      if (req[LW'(j)]) r = {1'b1, LW'(j)};
    end
    return r;
  endfunction

  logic [2:0][LW:0] pick;
  logic [2:0]       any_c;
  logic [1:0]       sel;
  logic [LW-1:0]    win;

  always_comb begin
    pick[CLS_OPS] = rr_pick(opsum_glb_write_req_matrix_i, ptr_q[CLS_OPS]);
    pick[CLS_IPS] = rr_pick(ipsum_read_req_matrix_i,      ptr_q[CLS_IPS]);
    pick[CLS_IFM] = rr_pick(ifmap_read_req_matrix_i,      ptr_q[CLS_IFM]);
    any_c = {pick[CLS_IFM][LW], pick[CLS_IPS][LW], pick[CLS_OPS][LW]};
    sel   = CLS_IFM;
`ifdef GLB_ARB_CLASS_RR_EN
    // Scan from the class pointer backwards so the nearest requesting class wins.
    for (int k = 2; k >= 0; k--) begin
      logic [1:0] c;
      c = 2'(({30'd0, cptr_q} + k) % 3);
      if (any_c[c]) sel = c;
    end
`else
    if (any_c[CLS_OPS])      sel = CLS_OPS;
    else if (any_c[CLS_IPS]) sel = CLS_IPS;
`endif
    win = pick[sel][LW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    ifm_push_d = '0;
    ips_push_d = '0;
    ops_pop_d  = '0;
    addr_d     = '0;
    web_d      = 4'hF;
    wdata_d    = '0;
    en_d       = 1'b0;
`ifdef GLB_ARB_CLASS_RR_EN
    cptr_d     = cptr_q;
`endif
    case (state_q)
      IDLE: if (|any_c) begin
        cls_d      = sel;
        idx_d      = win;
        ptr_d[sel] = (win == LW'(NUM_LANE-1)) ? '0 : win + 1'b1;
`ifdef GLB_ARB_CLASS_RR_EN
        cptr_d     = (sel == CLS_IFM) ? CLS_OPS : sel + 2'd1;
`endif
        en_d       = 1'b1;
        if (sel == CLS_OPS) begin
          state_d        = WR;
          addr_d         = opsum_glb_write_addr_matrix_i[win];
          web_d          = opsum_glb_write_web_matrix_i[win];
          wdata_d        = opsum_fifo_pop_data_matrix_i[win];
          ops_pop_d[win] = 1'b1;
        end else begin
          state_d = RD_ADDR;
          addr_d  = (sel == CLS_IPS) ? ipsum_glb_read_addr_matrix_i[win]
                                     : ifmap_glb_read_addr_matrix_i[win];
        end
      end
      RD_ADDR: begin
        state_d = RD_DATA;
        if (cls_q == CLS_IPS) ips_push_d[idx_q] = 1'b1;
        else                  ifm_push_d[idx_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cls_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      ifm_push_q <= '0;
      ips_push_q <= '0;
      ops_pop_q  <= '0;
      addr_q     <= '0;
      web_q      <= 4'hF;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef GLB_ARB_CLASS_RR_EN
      cptr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      ifm_push_q <= ifm_push_d;
      ips_push_q <= ips_push_d;
      ops_pop_q  <= ops_pop_d;
      addr_q     <= addr_d;
      web_q      <= web_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
`ifdef GLB_ARB_CLASS_RR_EN
      cptr_q     <= cptr_d;
`endif
    end
  end

  assign ifmap_permit_push_matrix_o = ifm_push_q;
  assign ipsum_permit_push_matrix_o = ips_push_q;
  assign opsum_permit_pop_matrix_o  = ops_pop_q;
  assign glb_addr_o                 = addr_q;
  assign glb_web_o                  = web_q;
  assign glb_wdata_o                = wdata_q;
  assign glb_en_o                   = en_q;
  assign fifo_glb_busy_o            = busy_q;
endmodule

// File: tb/tb_glb_fifo_arbiter.sv
// Directed bench for glb_fifo_arbiter: reset, read/write latency, lane RR, class order.
module tb_glb_fifo_arbiter;
  localparam int NL = 32;
  localparam int AW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NL-1:0]          ifm_req, ips_req, ops_req;
  logic [NL-1:0][AW-1:0]  ifm_addr, ips_addr, ops_addr;
  logic [NL-1:0][3:0]     ops_web;
  logic [NL-1:0][31:0]    ops_data;
  logic [NL-1:0]          ifm_push, ips_push, ops_pop;
  logic [AW-1:0]          glb_addr;
  logic [3:0]             glb_web;
  logic [31:0]            glb_wdata;
  logic                   glb_en, busy;

  int n_chk = 0;
  int n_fail = 0;

  glb_fifo_arbiter #(.NUM_LANE(NL), .ADDR_W(AW)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .ifmap_read_req_matrix_i        (ifm_req),
    .ifmap_glb_read_addr_matrix_i   (ifm_addr),
    .ipsum_read_req_matrix_i        (ips_req),
    .ipsum_glb_read_addr_matrix_i   (ips_addr),
    .opsum_glb_write_req_matrix_i   (ops_req),
    .opsum_glb_write_addr_matrix_i  (ops_addr),
    .opsum_glb_write_web_matrix_i   (ops_web),
    .opsum_fifo_pop_data_matrix_i   (ops_data),
    .ifmap_permit_push_matrix_o     (ifm_push),
    .ipsum_permit_push_matrix_o     (ips_push),
    .opsum_permit_pop_matrix_o      (ops_pop),
    .glb_addr_o                     (glb_addr),
    .glb_web_o                      (glb_web),
    .glb_wdata_o                    (glb_wdata),
    .glb_en_o                       (glb_en),
    .fifo_glb_busy_o                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks that no permit of any class is high.
  task automatic chk_no_permit(input string tag);
    chk(tag, {ifm_push, ips_push, ops_pop}, '0);
  endtask

  // One read cycle pair: RD_ADDR then RD_DATA for the given class/lane.
  task automatic chk_read(input string tag, input bit is_ips, input int lane, input logic [31:0] addr);
    logic [NL-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    tick();
    chk({tag, "_addr"}, {glb_en, glb_web, glb_addr}, {1'b1, 4'hF, addr});
    chk({tag, "_busy1"}, busy, 1'b1);
    tick();
    chk({tag, "_push"}, {ifm_push, ips_push, ops_pop}, is_ips ? {NL'(0), oh, NL'(0)} : {oh, NL'(0), NL'(0)});
    chk({tag, "_en0"}, {busy, glb_en}, 2'b10);
  endtask

  initial begin
    rst = 1'b1;
    ifm_req = '0; ips_req = '0; ops_req = '0;
    ops_web = '0; ops_data = '0;
    for (int i = 0; i < NL; i++) begin
      ifm_addr[i] = 32'h2000 + 32'(i) * 4;
      ips_addr[i] = 32'h1000 + 32'(i) * 4;
      ops_addr[i] = 32'h3000 + 32'(i) * 4;
    end
    ifm_addr[5] = 32'h40;
    ops_addr[9] = 32'h100;
    ops_web[9]  = 4'h0;
    ops_data[9] = 32'h12345678;
    ops_web[2]  = 4'h3;
    ops_data[2] = 32'hCAFE0002;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {glb_en, glb_web, glb_addr, glb_wdata}, {1'b0, 4'hF, 32'h0, 32'h0});
    chk("rst_busy", busy, 1'b0);
    chk_no_permit("rst_perm");
    rst = 1'b0;
    tick();
    chk("idle_busy", {busy, glb_en, glb_web}, {2'b00, 4'hF});

    // Reset during RD_ADDR of ifmap lane 3 clears everything immediately.
    ifm_req[3] = 1'b1;
    tick();
    chk("r3_addr", {glb_en, glb_addr}, {1'b1, 32'h200C});
    ifm_req[3] = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {busy, glb_en, glb_web}, {2'b00, 4'hF});
    chk_no_permit("mid_rst_perm");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_no_permit("post_rst_perm");
      chk("post_rst_busy", busy, 1'b0);
    end

    // Single read, ifmap lane 5; request dropped during RD_ADDR.
    ifm_req[5] = 1'b1;
    tick();
    chk("rd_addr", {glb_en, glb_web, glb_addr}, {1'b1, 4'hF, 32'h40});
    chk("rd_busy1", busy, 1'b1);
    ifm_req[5] = 1'b0;
    tick();
    chk("rd_push", ifm_push, 32'h20);
    chk("rd_busy2", busy, 1'b1);
    chk("rd_other", {ips_push, ops_pop}, '0);
    tick();
    chk("rd_idle", busy, 1'b0);
    chk_no_permit("rd_idle_perm");

    // Single write, opsum lane 9.
    ops_req[9] = 1'b1;
    tick();
    chk("wr_bus", {glb_en, glb_web, glb_addr, glb_wdata}, {1'b1, 4'h0, 32'h100, 32'h12345678});
    chk("wr_pop", ops_pop, 32'h200);
    chk("wr_busy", busy, 1'b1);
    ops_req[9] = 1'b0;
    tick();
    chk("wr_idle", {busy, glb_en, glb_web}, {2'b00, 4'hF});
    chk_no_permit("wr_idle_perm");

    // Lane round-robin with wrap on ipsum: 0, 7, 31, 0, 7.
    ips_req[0] = 1'b1; ips_req[7] = 1'b1; ips_req[31] = 1'b1;
    chk_read("rr0a", 1'b1, 0,  32'h1000);
    tick(); chk("rr_gap0", busy, 1'b0);
    chk_read("rr7a", 1'b1, 7,  32'h101C);
    tick(); chk("rr_gap1", busy, 1'b0);
    chk_read("rr31", 1'b1, 31, 32'h107C);
    tick(); chk("rr_gap2", busy, 1'b0);
    chk_read("rr0b", 1'b1, 0,  32'h1000);
    tick(); chk("rr_gap3", busy, 1'b0);
    chk_read("rr7b", 1'b1, 7,  32'h101C);
    ips_req = '0;
    tick();
    chk("rr_end", busy, 1'b0);

    // Class ordering with lane 2 of every class requesting; fresh pointers.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifm_req[2] = 1'b1; ips_req[2] = 1'b1; ops_req[2] = 1'b1;
`ifdef GLB_ARB_CLASS_RR_EN
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("crr_wr", {ops_pop, glb_web, glb_wdata}, {32'h4, 4'h3, 32'hCAFE0002});
      tick();
      chk("crr_gap_w", busy, 1'b0);
      chk_read("crr_ips", 1'b1, 2, 32'h1008);
      tick();
      chk("crr_gap_p", busy, 1'b0);
      chk_read("crr_ifm", 1'b0, 2, 32'h2008);
      tick();
      chk("crr_gap_i", busy, 1'b0);
    end
    ifm_req = '0; ips_req = '0; ops_req = '0;
`else
    tick();
    chk("pri_wr", {glb_en, glb_addr, glb_web, glb_wdata}, {1'b1, 32'h3008, 4'h3, 32'hCAFE0002});
    chk("pri_pop", ops_pop, 32'h4);
    ops_req[2] = 1'b0;
    tick();
    chk("pri_gap_w", busy, 1'b0);
    chk_read("pri_ips", 1'b1, 2, 32'h1008);
    ips_req[2] = 1'b0;
    tick();
    chk("pri_gap_p", busy, 1'b0);
    chk_read("pri_ifm", 1'b0, 2, 32'h2008);
    ifm_req[2] = 1'b0;
`endif
    tick();
    chk("final_idle", busy, 1'b0);
    tick();
    chk("final_quiet", {busy, glb_en, glb_web}, {2'b00, 4'hF});
    chk_no_permit("final_perm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // At most one permit among all 96 lanes in any cycle.
  always @(negedge clk) begin
    if (!$onehot0({ifm_push, ips_push, ops_pop})) begin
      n_fail++;
      $display("FAIL onehot: permits %0h required at most one bit", {ifm_push, ips_push, ops_pop});
    end
  end
endmodule
